// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types, LED patterns and saturating add for the vending controller
// Purpose : state encoding, green-LED patterns per state and a width-generic
//           saturating adder used for coin credit accumulation.
// Ports   : none (package).
package vend_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_PAYMENT,
      ST_DISPENSE,
      ST_COMPLETE,
      ST_REFUND
   } state_t;

   localparam logic [2:0] LED_OFF      = 3'b000;
   localparam logic [2:0] LED_SELECT   = 3'b111;
   localparam logic [2:0] LED_PAYMENT  = 3'b011;
   localparam logic [2:0] LED_DISPENSE = 3'b001;

   // a + b clamped to 2^w - 1; operands are zero-extended values of width w (w <= 31)
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
      logic [32:0] sum;
      logic [32:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (33'd1 << w) - 33'd1;
      return (sum > lim) ? lim[31:0] : sum[31:0];
   endfunction

endpackage

// File: rtl/vending_controller_if.sv
// rtl/vending_controller_if.sv - front-end/driver bundle of the vending controller
// Purpose : groups keypad, coin, IR, restock inputs and LED/motor/buzzer/display/change
//           outputs. master = front-end side, slave = controller side.
// Signals : start, sel_valid, sel_idx, coin_valid, coin_value, cancel, price_tbl,
//           item_detected, restock_valid, restock_qty (to controller);
//           disp_value, red_led, green_leds, motor_en, buzzer, change_valid,
//           change_amt, fault (from controller).
interface vending_controller_if #(
   parameter int NUM_ITEMS = 4,
   parameter int PRICE_W   = 8,
   parameter int STOCK_W   = 4
);
   localparam int IDX_W = $clog2(NUM_ITEMS);

   logic                         start;
   logic                         sel_valid;
   logic [IDX_W-1:0]             sel_idx;
   logic                         coin_valid;
   logic [PRICE_W-1:0]           coin_value;
   logic                         cancel;
   logic [NUM_ITEMS*PRICE_W-1:0] price_tbl;
   logic                         item_detected;
   logic                         restock_valid;
   logic [STOCK_W-1:0]           restock_qty;
   logic [PRICE_W-1:0]           disp_value;
   logic                         red_led;
   logic [2:0]                   green_leds;
   logic                         motor_en;
   logic                         buzzer;
   logic                         change_valid;
   logic [PRICE_W-1:0]           change_amt;
   logic                         fault;

   modport master (
      output start, sel_valid, sel_idx, coin_valid, coin_value, cancel, price_tbl,
             item_detected, restock_valid, restock_qty,
      input  disp_value, red_led, green_leds, motor_en, buzzer, change_valid, change_amt, fault
   );

   modport slave (
      input  start, sel_valid, sel_idx, coin_valid, coin_value, cancel, price_tbl,
             item_detected, restock_valid, restock_qty,
      output disp_value, red_led, green_leds, motor_en, buzzer, change_valid, change_amt, fault
   );

endinterface

// File: rtl/vend_timer.sv
// rtl/vend_timer.sv - loadable down-counter with clear and single-cycle expiry pulse
// Purpose : load arms the counter with load_val; it counts down to 0, pulses
//           expired for one cycle at 0 and then stops until reloaded.
// Ports   : clk, reset (async, active-high), load, load_val, clear, expired.
module vend_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         clear,
   output logic         expired
);

   logic [W-1:0] count_q, count_d;
   logic         run_q, run_d;

   always_comb begin
      count_d = count_q;
      run_d   = run_q;
      if (clear) begin
         run_d = 1'b0;
      end else if (load) begin
         count_d = load_val;
         run_d   = 1'b1;
      end else if (run_q) begin
         if (count_q == '0) run_d = 1'b0;
         else               count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         run_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         run_q   <= run_d;
      end
   end

   assign expired = run_q && (count_q == '0);

endmodule

// File: rtl/vending_controller.sv
// rtl/vending_controller.sv - multi-item vending FSM with credit, change, refund and timeouts
// Purpose : IDLE/SELECT/PAYMENT/DISPENSE/COMPLETE/REFUND sequencing; one shared timer
//           covers selection/payment, motor and buzzer timing. All outputs registered.
// Ports   : clk, reset (async, active-high), bus (vending_controller_if.slave).
// Config  : VEND_STOCK_TRACK_EN enables per-item stock counters.
module vending_controller
   import vend_pkg::*;
#(
   parameter int NUM_ITEMS    = 4,
   parameter int PRICE_W      = 8,
   parameter int STOCK_W      = 4,
   parameter int SEL_TO_CYC   = 5000000,
   parameter int MOTOR_TO_CYC = 2000000,
   parameter int BUZZ_CYC     = 500000
) (
   input logic                 clk,
   input logic                 reset,
   vending_controller_if.slave bus
);

   localparam int IDX_W    = $clog2(NUM_ITEMS);
   localparam int IDX_SPAN = 1 << IDX_W;
   localparam int TMR_MAX  = (SEL_TO_CYC > MOTOR_TO_CYC) ?
                             ((SEL_TO_CYC > BUZZ_CYC) ? SEL_TO_CYC : BUZZ_CYC) :
                             ((MOTOR_TO_CYC > BUZZ_CYC) ? MOTOR_TO_CYC : BUZZ_CYC);
   localparam int TMR_W    = $clog2(TMR_MAX + 1);

   state_t             state_q, state_d;
   logic [PRICE_W-1:0] credit_q, credit_d, price_q, price_d, pend_amt_q, pend_amt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               fault_q, fault_d, pend_valid_q, pend_valid_d;
   logic [PRICE_W-1:0] disp_value_q, disp_value_d, change_amt_q, change_amt_d;
   logic               red_led_q, red_led_d, motor_en_q, motor_en_d, buzzer_q, buzzer_d;
   logic               change_valid_q, change_valid_d;
   logic [2:0]         green_leds_q, green_leds_d;

   logic [IDX_SPAN-1:0] in_range, avail;
   logic [PRICE_W-1:0]  sel_price, own_amt;
   logic                own_strobe, dec_stock, stray_coin, any_input, timed_out;
   logic                tmr_load, tmr_clear, tmr_expired;
   logic [TMR_W-1:0]    tmr_val;

   vend_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .clear    (tmr_clear),
      .expired  (tmr_expired)
   );

   always_comb begin
      in_range  = '0;
      sel_price = '0;
      for (int i = 0; i < IDX_SPAN; i++) in_range[i] = (i < NUM_ITEMS);
      for (int i = 0; i < NUM_ITEMS; i++)
         if (bus.sel_idx == IDX_W'(i)) sel_price = bus.price_tbl[i*PRICE_W +: PRICE_W];
   end

`ifdef VEND_STOCK_TRACK_EN
   logic [STOCK_W-1:0] stock_q [IDX_SPAN];
   logic [STOCK_W-1:0] stock_d [IDX_SPAN];

   always_comb begin
      avail = '0;
      for (int i = 0; i < IDX_SPAN; i++) avail[i] = in_range[i] && (stock_q[i] != '0);
   end

   always_comb begin
      for (int i = 0; i < IDX_SPAN; i++) stock_d[i] = stock_q[i];
      if (state_q == ST_IDLE && bus.restock_valid) stock_d[bus.sel_idx] = bus.restock_qty;
      if (dec_stock && stock_q[idx_q] != '0) stock_d[idx_q] = stock_q[idx_q] - 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < IDX_SPAN; i++) stock_q[i] <= '0;
      end else begin
         for (int i = 0; i < IDX_SPAN; i++) stock_q[i] <= stock_d[i];
      end
   end
`else
   logic               unused_stock;
   logic [STOCK_W-1:0] unused_qty;
   assign avail        = in_range;
   assign unused_qty   = bus.restock_qty;
   assign unused_stock = ^{dec_stock, idx_q, bus.restock_valid, unused_qty};
`endif

   always_comb begin
      state_d    = state_q;
      credit_d   = credit_q;
      price_d    = price_q;
      idx_d      = idx_q;
      fault_d    = fault_q;
      own_strobe = 1'b0;
      own_amt    = '0;
      dec_stock  = 1'b0;
      // any keypad/coin activity restarts the inactivity window, so it also masks expiry
      any_input  = bus.sel_valid || bus.coin_valid;
      timed_out  = tmr_expired && !any_input;
      if (bus.start) fault_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d  = ST_SELECT;
               credit_d = '0;
               price_d  = '0;
            end
         end
         ST_SELECT: begin
            if (bus.cancel) begin
               state_d = ST_IDLE;
            end else if (bus.sel_valid && avail[bus.sel_idx]) begin
               state_d = ST_PAYMENT;
               idx_d   = bus.sel_idx;
               price_d = sel_price;
            end else if (timed_out) begin
               state_d = ST_IDLE;
            end
         end
         ST_PAYMENT: begin
            if (bus.coin_valid)
               credit_d = PRICE_W'(sat_add(32'(credit_q), 32'(bus.coin_value), PRICE_W));
            // cancel refunds whatever is held, including a coin arriving in the same cycle
            if (bus.cancel || timed_out) begin
               state_d    = ST_REFUND;
               own_strobe = 1'b1;
               own_amt    = credit_d;
            end else if (credit_d >= price_q) begin
               state_d = ST_DISPENSE;
            end
         end
         ST_DISPENSE: begin
            if (bus.item_detected) begin
               state_d    = ST_COMPLETE;
               own_strobe = (credit_q != price_q);
               own_amt    = credit_q - price_q;
               dec_stock  = 1'b1;
            end else if (tmr_expired) begin
               state_d    = ST_REFUND;
               fault_d    = 1'b1;
               own_strobe = 1'b1;
               own_amt    = credit_q;
            end
         end
         ST_COMPLETE: begin
            if (tmr_expired) begin
               state_d  = ST_IDLE;
               credit_d = '0;
            end
         end
         ST_REFUND: begin
            state_d  = ST_IDLE;
            credit_d = '0;
         end
         default: state_d = ST_IDLE;
      endcase

      tmr_load  = 1'b0;
      tmr_clear = 1'b0;
      tmr_val   = '0;
      if (state_d != state_q) begin
         case (state_d)
            ST_SELECT, ST_PAYMENT: begin tmr_load = 1'b1; tmr_val = TMR_W'(SEL_TO_CYC - 1);   end
            ST_DISPENSE:           begin tmr_load = 1'b1; tmr_val = TMR_W'(MOTOR_TO_CYC - 1); end
            ST_COMPLETE:           begin tmr_load = 1'b1; tmr_val = TMR_W'(BUZZ_CYC - 1);     end
            default:               tmr_clear = 1'b1;
         endcase
      end else if ((state_q == ST_SELECT || state_q == ST_PAYMENT) && any_input) begin
         tmr_load = 1'b1;
         tmr_val  = TMR_W'(SEL_TO_CYC - 1);
      end
   end

   // change output: own change/refund wins; a stray coin colliding with it waits one cycle
   always_comb begin
      stray_coin     = bus.coin_valid && (state_q != ST_PAYMENT);
      change_valid_d = 1'b0;
      change_amt_d   = '0;
      pend_valid_d   = pend_valid_q;
      pend_amt_d     = pend_amt_q;
      if (own_strobe) begin
         change_valid_d = 1'b1;
         change_amt_d   = own_amt;
         if (stray_coin) begin
            pend_valid_d = 1'b1;
            pend_amt_d   = bus.coin_value;
         end
      end else if (pend_valid_q) begin
         change_valid_d = 1'b1;
         change_amt_d   = pend_amt_q;
         pend_valid_d   = stray_coin;
         pend_amt_d     = bus.coin_value;
      end else if (stray_coin) begin
         change_valid_d = 1'b1;
         change_amt_d   = bus.coin_value;
      end
   end

   always_comb begin
      red_led_d    = (state_d == ST_IDLE);
      motor_en_d   = (state_d == ST_DISPENSE);
      buzzer_d     = (state_d == ST_COMPLETE);
      green_leds_d = LED_OFF;
      disp_value_d = '0;
      case (state_d)
         ST_SELECT:   begin green_leds_d = LED_SELECT;  disp_value_d = price_d;            end
         ST_PAYMENT:  begin green_leds_d = LED_PAYMENT; disp_value_d = price_d - credit_d; end
         ST_DISPENSE: green_leds_d = LED_DISPENSE;
         default:     green_leds_d = LED_OFF;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         credit_q       <= '0;
         price_q        <= '0;
         idx_q          <= '0;
         fault_q        <= 1'b0;
         pend_valid_q   <= 1'b0;
         pend_amt_q     <= '0;
         red_led_q      <= 1'b1;
         green_leds_q   <= LED_OFF;
         motor_en_q     <= 1'b0;
         buzzer_q       <= 1'b0;
         disp_value_q   <= '0;
         change_valid_q <= 1'b0;
         change_amt_q   <= '0;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         price_q        <= price_d;
         idx_q          <= idx_d;
         fault_q        <= fault_d;
         pend_valid_q   <= pend_valid_d;
         pend_amt_q     <= pend_amt_d;
         red_led_q      <= red_led_d;
         green_leds_q   <= green_leds_d;
         motor_en_q     <= motor_en_d;
         buzzer_q       <= buzzer_d;
         disp_value_q   <= disp_value_d;
         change_valid_q <= change_valid_d;
         change_amt_q   <= change_amt_d;
      end
   end

   assign bus.red_led      = red_led_q;
   assign bus.green_leds   = green_leds_q;
   assign bus.motor_en     = motor_en_q;
   assign bus.buzzer       = buzzer_q;
   assign bus.disp_value   = disp_value_q;
   assign bus.change_valid = change_valid_q;
   assign bus.change_amt   = change_amt_q;
   assign bus.fault        = fault_q;

endmodule

// File: tb/tb_vending_controller.sv
// tb/tb_vending_controller.sv - directed self-checking bench for vending_controller
module tb_vending_controller;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   vending_controller_if #(.NUM_ITEMS(4), .PRICE_W(8), .STOCK_W(4)) vif ();

   vending_controller #(
      .NUM_ITEMS(4), .PRICE_W(8), .STOCK_W(4),
      .SEL_TO_CYC(20), .MOTOR_TO_CYC(30), .BUZZ_CYC(5)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (vif)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      vif.start = 1'b1; tick(); vif.start = 1'b0;
   endtask

   task automatic do_sel(input logic [1:0] idx);
      vif.sel_valid = 1'b1; vif.sel_idx = idx; tick(); vif.sel_valid = 1'b0;
   endtask

   task automatic do_coin(input logic [7:0] v, input logic with_cancel, input logic with_item);
      vif.coin_valid = 1'b1; vif.coin_value = v;
      vif.cancel = with_cancel; vif.item_detected = with_item;
      tick();
      vif.coin_valid = 1'b0; vif.cancel = 1'b0; vif.item_detected = 1'b0;
   endtask

   task automatic do_item();
      vif.item_detected = 1'b1; tick(); vif.item_detected = 1'b0;
   endtask

   task automatic do_cancel();
      vif.cancel = 1'b1; tick(); vif.cancel = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (!vif.red_led && n < 100) begin
         tick();
         n++;
      end
      check(tag, 32'(vif.red_led), 1);
   endtask

   initial begin
      int  n;
      logic saw_chg;
      vif.start = 0; vif.sel_valid = 0; vif.sel_idx = 0; vif.coin_valid = 0;
      vif.coin_value = 0; vif.cancel = 0; vif.item_detected = 0;
      vif.restock_valid = 0; vif.restock_qty = 0;
      vif.price_tbl = {8'd255, 8'd50, 8'd35, 8'd0};
      repeat (3) tick();
      reset = 1'b0;
      tick();

      check("rst_red", 32'(vif.red_led), 1);
      check("rst_green", 32'(vif.green_leds), 0);
      check("rst_disp", 32'(vif.disp_value), 0);
      check("rst_motor", 32'(vif.motor_en), 0);
      check("rst_buzz", 32'(vif.buzzer), 0);
      check("rst_chg", 32'(vif.change_valid), 0);
      check("rst_fault", 32'(vif.fault), 0);

      // exact pay
      do_start();
      check("t1_select", 32'(vif.green_leds), 32'h7);
      do_sel(2'd2);
      check("t1_payment", 32'(vif.green_leds), 32'h3);
      check("t1_disp50", 32'(vif.disp_value), 50);
      do_coin(8'd20, 1'b0, 1'b0);
      check("t1_disp30", 32'(vif.disp_value), 30);
      do_coin(8'd30, 1'b0, 1'b0);
      check("t1_dispense", 32'(vif.green_leds), 32'h1);
      check("t1_motor", 32'(vif.motor_en), 1);
      check("t1_nochg", 32'(vif.change_valid), 0);
      do_item();
      check("t1_buzz_on", 32'(vif.buzzer), 1);
      saw_chg = vif.change_valid;
      n = 1;
      while (vif.buzzer && n < 50) begin
         tick();
         if (vif.buzzer) n++;
         saw_chg = saw_chg | vif.change_valid;
      end
      check("t1_buzz_cyc", 32'(n), 5);
      check("t1_nochg_complete", 32'(saw_chg), 0);
      check("t1_idle", 32'(vif.red_led), 1);

      // overpay, with a stray coin colliding with the change strobe
      do_start();
      do_sel(2'd1);
      check("t2_disp35", 32'(vif.disp_value), 35);
      do_coin(8'd25, 1'b0, 1'b0);
      check("t2_disp10", 32'(vif.disp_value), 10);
      do_coin(8'd25, 1'b0, 1'b0);
      check("t2_dispense", 32'(vif.motor_en), 1);
      do_coin(8'd5, 1'b0, 1'b1);
      check("t2_chg_v", 32'(vif.change_valid), 1);
      check("t2_chg_amt", 32'(vif.change_amt), 15);
      tick();
      check("t2_stray_v", 32'(vif.change_valid), 1);
      check("t2_stray_amt", 32'(vif.change_amt), 5);
      tick();
      check("t2_chg_off", 32'(vif.change_valid), 0);
      wait_idle("t2_idle");

      // cancel after a coin
      do_start();
      do_sel(2'd3);
      check("t3_disp255", 32'(vif.disp_value), 255);
      do_coin(8'd10, 1'b0, 1'b0);
      check("t3_disp245", 32'(vif.disp_value), 245);
      do_cancel();
      check("t3_ref_v", 32'(vif.change_valid), 1);
      check("t3_ref_amt", 32'(vif.change_amt), 10);
      check("t3_ref_green", 32'(vif.green_leds), 0);
      tick();
      check("t3_idle", 32'(vif.red_led), 1);
      check("t3_chg_off", 32'(vif.change_valid), 0);

      // coin and cancel in the same cycle
      do_start();
      do_sel(2'd3);
      do_coin(8'd7, 1'b0, 1'b0);
      do_coin(8'd8, 1'b1, 1'b0);
      check("t3b_ref_v", 32'(vif.change_valid), 1);
      check("t3b_ref_amt", 32'(vif.change_amt), 15);
      tick();
      check("t3b_idle", 32'(vif.red_led), 1);

      // saturation then motor fault
      do_start();
      do_sel(2'd3);
      do_coin(8'd250, 1'b0, 1'b0);
      check("t4_disp5", 32'(vif.disp_value), 5);
      do_coin(8'd10, 1'b0, 1'b0);
      check("t4_motor", 32'(vif.motor_en), 1);
      n = 1;
      while (vif.motor_en && n < 100) begin
         tick();
         if (vif.motor_en) n++;
      end
      check("t4_motor_cyc", 32'(n), 30);
      check("t4_ref_v", 32'(vif.change_valid), 1);
      check("t4_ref_sat", 32'(vif.change_amt), 255);
      check("t4_fault", 32'(vif.fault), 1);
      tick();
      check("t4_idle", 32'(vif.red_led), 1);
      check("t4_fault_sticky", 32'(vif.fault), 1);
      do_start();
      check("t4_fault_clr", 32'(vif.fault), 0);

      // select timeout
      n = 1;
      while (vif.green_leds == 3'b111 && n < 100) begin
         tick();
         if (vif.green_leds == 3'b111) n++;
      end
      check("t5_sel_to", 32'(n), 20);
      check("t5_idle", 32'(vif.red_led), 1);

      // stray coin in IDLE
      do_coin(8'd5, 1'b0, 1'b0);
      check("t5_stray_v", 32'(vif.change_valid), 1);
      check("t5_stray_amt", 32'(vif.change_amt), 5);
      tick();
      check("t5_stray_off", 32'(vif.change_valid), 0);

      // stock: restock item 0 (price 0) with 1, buy it, reselect
      vif.sel_idx = 2'd0; vif.restock_qty = 4'd1; vif.restock_valid = 1'b1;
      tick();
      vif.restock_valid = 1'b0;
      do_start();
      do_sel(2'd0);
      check("t6_payment", 32'(vif.green_leds), 32'h3);
      check("t6_disp0", 32'(vif.disp_value), 0);
      tick();
      check("t6_free_dispense", 32'(vif.motor_en), 1);
      do_item();
      check("t6_nochg", 32'(vif.change_valid), 0);
      wait_idle("t6_idle");
      do_start();
      do_sel(2'd0);
`ifdef VEND_STOCK_TRACK_EN
      check("t6_sold_out", 32'(vif.green_leds), 32'h7);
`else
      check("t6_untracked", 32'(vif.green_leds), 32'h3);
`endif
      do_cancel();
      wait_idle("t6_end");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
